// File: rtl/id_branch_resolve.sv
// ID-stage branch resolution: signed/unsigned compare, six branch conditions,
// a registered valid/ready result stage and a table of 2-bit direction predictors.
module id_branch_resolve #(
  parameter int WIDTH     = 32,
  parameter int PHT_DEPTH = 16,
  parameter int PC_W      = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       br_op,
  input  logic [PC_W-1:0]  br_pc,
  input  logic             br_pred,
  input  logic [WIDTH-1:0] rD1,
  input  logic [WIDTH-1:0] rD2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       cmp,
  output logic             taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(PHT_DEPTH);

  localparam logic [2:0] OP_BEQ  = 3'd0;
  localparam logic [2:0] OP_BNE  = 3'd1;
  localparam logic [2:0] OP_BLT  = 3'd2;
  localparam logic [2:0] OP_BGE  = 3'd3;
  localparam logic [2:0] OP_BLTU = 3'd4;
  localparam logic [2:0] OP_BGEU = 3'd5;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] br_idx;
  logic [1:0]       pht_rd [PHT_DEPTH];

  logic             is_unsigned;
  logic             op_valid;
  logic [WIDTH:0]   opa_ext;
  logic [WIDTH:0]   opb_ext;
  logic [WIDTH:0]   diff;
  logic             is_eq;
  logic             is_lt;
  logic [1:0]       cmp_d;
  logic             taken_d;
  logic             mispredict_d;

  logic             accept;
  logic             out_valid_d;
  logic             pht_we;
  logic [1:0]       pht_cur;
  logic [1:0]       pht_next;

  logic             out_valid_q;
  logic [1:0]       cmp_q;
  logic             taken_q;
  logic             mispredict_q;
  logic [CNT_W-1:0] cnt_q;

  logic             unused_bits;

  assign if_idx = if_pc[2 +: IDX_W];
  assign br_idx = br_pc[2 +: IDX_W];

  // Table state is registered, so a same-cycle update is only visible next cycle.
  assign if_pred_taken = pht_rd[if_idx][1];

  // One extra bit keeps the difference exact, so signed overflow cannot flip LT/GT.
  always_comb begin
    is_unsigned = (br_op == OP_BLTU) || (br_op == OP_BGEU);
    op_valid    = (br_op <= OP_BGEU);
    opa_ext     = {(is_unsigned ? 1'b0 : rD1[WIDTH-1]), rD1};
    opb_ext     = {(is_unsigned ? 1'b0 : rD2[WIDTH-1]), rD2};
    diff        = opa_ext - opb_ext;
    is_eq       = (rD1 == rD2);
    is_lt       = !is_eq && diff[WIDTH];
    if (is_eq) begin
      cmp_d = CMP_EQ;
    end else if (is_lt) begin
      cmp_d = CMP_LT;
    end else begin
      cmp_d = CMP_GT;
    end
  end

  always_comb begin
    taken_d = 1'b0;
    case (br_op)
      OP_BEQ:           taken_d = is_eq;
      OP_BNE:           taken_d = !is_eq;
      OP_BLT, OP_BLTU:  taken_d = is_lt;
      OP_BGE, OP_BGEU:  taken_d = !is_lt;
      default:          taken_d = 1'b0;
    endcase
    mispredict_d = taken_d ^ br_pred;
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      cmp_q        <= CMP_EQ;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        cmp_q        <= cmp_d;
        taken_q      <= taken_d;
        mispredict_q <= mispredict_d;
        if (mispredict_d && (cnt_q != CNT_MAX)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign pht_we  = accept && op_valid;
  assign pht_cur = pht_rd[br_idx];

  always_comb begin
    if (taken_d) begin
      pht_next = (pht_cur == 2'b11) ? 2'b11 : pht_cur + 2'd1;
    end else begin
      pht_next = (pht_cur == 2'b00) ? 2'b00 : pht_cur - 2'd1;
    end
  end

  // Each predictor is its own register so reset can restore all entries at once.
  genvar gi;
  generate
    for (gi = 0; gi < PHT_DEPTH; gi++) begin : g_pht
      logic [1:0] entry_q;
      logic       hit;

      assign hit = pht_we && (br_idx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          entry_q <= 2'b01;
        end else if (hit) begin
          entry_q <= pht_next;
        end
      end

      assign pht_rd[gi] = entry_q;
    end
  endgenerate

  assign out_valid      = out_valid_q;
  assign cmp            = cmp_q;
  assign taken          = taken_q;
  assign mispredict     = mispredict_q;
  assign mispredict_cnt = cnt_q;

  assign unused_bits = ^{if_pc, br_pc, diff[WIDTH-1:0]};

endmodule

// File: tb/tb_id_branch_resolve.sv
// Directed bench for id_branch_resolve; counter width shrunk to 3 so saturation is reachable.
module tb_id_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  br_op;
  logic [31:0] br_pc;
  logic        br_pred;
  logic [31:0] rD1;
  logic [31:0] rD2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  cmp;
  logic        taken;
  logic        mispredict;
  logic [2:0]  mispredict_cnt;

  int errors  = 0;
  int checks  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  id_branch_resolve #(
    .WIDTH(32), .PHT_DEPTH(16), .PC_W(32), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .in_valid(in_valid), .in_ready(in_ready), .br_op(br_op), .br_pc(br_pc),
    .br_pred(br_pred), .rD1(rD1), .rD2(rD2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .cmp(cmp), .taken(taken),
    .mispredict(mispredict), .mispredict_cnt(mispredict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] pc, input logic pred,
                      input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    br_op    = op;
    br_pc    = pc;
    br_pred  = pred;
    rD1      = a;
    rD2      = b;
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    #1;
    check(tag, if_pred_taken, exp);
  endtask

  task automatic expect_res(input string tag, input logic [1:0] c, input logic t, input logic m);
    if (m && exp_cnt < 7) exp_cnt++;
    $display("txn %s: out_valid=%0d cmp=%0d taken=%0d mispredict=%0d cnt=%0d",
             tag, out_valid, cmp, taken, mispredict, mispredict_cnt);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".cmp"}, cmp, c);
    check({tag, ".taken"}, taken, t);
    check({tag, ".mispredict"}, mispredict, m);
    check({tag, ".cnt"}, mispredict_cnt, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; if_pc = '0; in_valid = 1'b0; br_op = '0; br_pc = '0; br_pred = 1'b0;
    rD1 = '0; rD2 = '0; flush = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst.valid", out_valid, 0);
    check("rst.cnt", mispredict_cnt, 0);
    check("rst.cmp", cmp, 0);
    check("rst.taken", taken, 0);
    check("rst.mispredict", mispredict, 0);
    check("rst.in_ready", in_ready, 1);
    for (int i = 0; i < 16; i++) pred_at($sformatf("rst.pht%0d", i), i * 4, 1'b0);

    // Compare semantics, back-to-back with out_ready=1
    send(3'd2, 32'h104, 1'b0, 32'hFFFF_FFFF, 32'h1);
    tick(); expect_res("blt_neg", 2'b01, 1'b1, 1'b1);
    pred_at("blt_neg.pht1", 32'h04, 1'b1);
    send(3'd4, 32'h108, 1'b0, 32'hFFFF_FFFF, 32'h1);
    tick(); expect_res("bltu", 2'b10, 1'b0, 1'b0);
    send(3'd3, 32'h10C, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    tick(); expect_res("bge_ovf", 2'b10, 1'b1, 1'b0);
    send(3'd0, 32'h110, 1'b1, 32'h1234, 32'h1234);
    tick(); expect_res("beq", 2'b00, 1'b1, 1'b0);
    send(3'd1, 32'h120, 1'b0, 32'd5, 32'd6);
    tick(); expect_res("bne", 2'b01, 1'b1, 1'b1);
    send(3'd2, 32'h124, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
    tick(); expect_res("blt_ovf", 2'b01, 1'b1, 1'b0);
    send(3'd6, 32'h104, 1'b1, 32'd1, 32'd2);
    tick(); expect_res("inv_op", 2'b01, 1'b0, 1'b1);
    pred_at("inv_op.pht1_kept", 32'h04, 1'b1);
    in_valid = 1'b0;
    tick();
    check("idle.valid", out_valid, 0);

    // Backpressure
    out_ready = 1'b0;
    send(3'd2, 32'h18, 1'b1, 32'd3, 32'd9);
    tick(); expect_res("bp_first", 2'b01, 1'b1, 1'b0);
    send(3'd0, 32'h18, 1'b1, 32'd1, 32'd2);
    #1;
    check("bp.in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp.hold%0d.valid", i), out_valid, 1);
      check($sformatf("bp.hold%0d.cmp", i), cmp, 2'b01);
      check($sformatf("bp.hold%0d.taken", i), taken, 1);
      check($sformatf("bp.hold%0d.in_ready", i), in_ready, 0);
      check($sformatf("bp.hold%0d.cnt", i), mispredict_cnt, exp_cnt);
    end
    pred_at("bp.pht6_stable", 32'h18, 1'b1);
    out_ready = 1'b1;
    #1;
    check("bp.release.in_ready", in_ready, 1);
    tick(); expect_res("bp_second", 2'b01, 1'b0, 1'b1);
    send(3'd5, 32'h1C, 1'b1, 32'd2, 32'd1);
    tick(); expect_res("bp_third", 2'b10, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    check("bp.drain.valid", out_valid, 0);
    pred_at("bp.pht6_dec", 32'h18, 1'b0);

    // Predictor training on entry 0 with read/write collision
    if_pc = 32'h40;
    send(3'd0, 32'h40, 1'b0, 32'd7, 32'd7);
    #1;
    check("train.collide", if_pred_taken, 0);
    tick(); expect_res("train_t1", 2'b00, 1'b1, 1'b1);
    check("train.t1.pred", if_pred_taken, 1);
    send(3'd0, 32'h40, 1'b1, 32'd7, 32'd7);
    tick(); check("train.t2.pred", if_pred_taken, 1);
    tick(); check("train.t3.pred", if_pred_taken, 1);
    send(3'd1, 32'h40, 1'b0, 32'd7, 32'd7);
    tick(); check("train.n1.pred", if_pred_taken, 1);
    tick(); check("train.n2.pred", if_pred_taken, 0);
    tick(); check("train.n3.pred", if_pred_taken, 0);
    tick(); expect_res("train_n4", 2'b00, 1'b0, 1'b0);
    check("train.n4.pred", if_pred_taken, 0);
    send(3'd0, 32'h40, 1'b1, 32'd7, 32'd7);
    tick(); check("train.sat0.up1", if_pred_taken, 0);
    tick(); check("train.sat0.up2", if_pred_taken, 1);
    in_valid = 1'b0;
    tick();

    // Flush
    out_ready = 1'b0;
    send(3'd2, 32'h28, 1'b0, 32'd1, 32'd2);
    tick(); expect_res("fl_pre", 2'b01, 1'b1, 1'b1);
    flush = 1'b1;
    send(3'd2, 32'h2C, 1'b0, 32'd1, 32'd2);
    tick();
    check("flush.stall.valid", out_valid, 0);
    check("flush.stall.cnt", mispredict_cnt, exp_cnt);
    out_ready = 1'b1;
    #1;
    check("flush.in_ready", in_ready, 1);
    tick();
    check("flush.accept.valid", out_valid, 0);
    check("flush.accept.cnt", mispredict_cnt, exp_cnt);
    flush = 1'b0;
    in_valid = 1'b0;
    pred_at("flush.pht11", 32'h2C, 1'b0);

    // Reset during a stall
    out_ready = 1'b0;
    send(3'd3, 32'h30, 1'b0, 32'd5, 32'd3);
    tick(); expect_res("rs_pre", 2'b10, 1'b1, 1'b1);
    send(3'd2, 32'h30, 1'b0, 32'd1, 32'd2);
    tick();
    check("rs.stall.valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    exp_cnt = 0;
    check("rs.valid", out_valid, 0);
    check("rs.cmp", cmp, 0);
    check("rs.taken", taken, 0);
    check("rs.mispredict", mispredict, 0);
    check("rs.cnt", mispredict_cnt, 0);
    pred_at("rs.pht12", 32'h30, 1'b0);
    pred_at("rs.pht0", 32'h40, 1'b0);
    tick();
    check("rs.after.valid", out_valid, 0);

    // Counter saturation at 7
    out_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      send(3'd0, 32'h3C, 1'b0, 32'd7, 32'd7);
      tick(); expect_res($sformatf("sat%0d", k), 2'b00, 1'b1, 1'b1);
    end
    send(3'd1, 32'h3C, 1'b0, 32'd7, 32'd7);
    tick(); expect_res("sat_hold", 2'b00, 1'b0, 1'b0);
    check("sat.max", mispredict_cnt, 7);
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
